// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller: register-zero encoding,
// counter widths and the legal parameter ranges.
package hazard_pkg;

  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned LD_CNT_W = 4;
  localparam int unsigned MD_CNT_W = 6;

  localparam int unsigned LOAD_STALL_MIN = 1;
  localparam int unsigned LOAD_STALL_MAX = 15;
  localparam int unsigned MDU_CYCLES_MIN = 1;
  localparam int unsigned MDU_CYCLES_MAX = 63;

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down-counter that saturates at zero; used for load-stall and
// mult/div latency tracking.
module hazard_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         nonzero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / mult-div hazard stall and branch/jump flush control between IF/ID
// and ID/EX. Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MDU_CYCLES        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rs,
  input  logic                  ifid_uses_rt,
  input  logic                  ifid_jump,
  input  logic                  ifid_jr,
  input  logic                  branch_taken,
  input  logic                  idex_md_start,
  input  logic                  ifid_md_use,
  output logic                  stall,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  if (LOAD_STALL_CYCLES < LOAD_STALL_MIN || LOAD_STALL_CYCLES > LOAD_STALL_MAX) begin : g_bad_ld
    $error("hazard_ctrl_unit: LOAD_STALL_CYCLES out of range 1..15");
  end
  if (MDU_CYCLES < MDU_CYCLES_MIN || MDU_CYCLES > MDU_CYCLES_MAX) begin : g_bad_md
    $error("hazard_ctrl_unit: MDU_CYCLES out of range 1..63");
  end

  logic load_hit;
  logic ld_active;
  logic md_active;
  logic stall_raw;
  logic redirect;

  // A load into $0 never produces a usable value, so it never stalls.
  always_comb begin
    load_hit = idex_mem_read
            && (idex_rt != REG_ADDR_W'(REG_ZERO))
            && ((ifid_uses_rs && (ifid_rs == idex_rt))
             || (ifid_uses_rt && (ifid_rt == idex_rt)));
  end

  hazard_down_counter #(.W(LD_CNT_W)) u_ld_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_hit & ~ld_active),
    .load_val (LD_CNT_W'(LOAD_STALL_CYCLES - 1)),
    .nonzero  (ld_active)
  );

  // A new mult/div restarts the latency window even if one is in flight.
  hazard_down_counter #(.W(MD_CNT_W)) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (idex_md_start),
    .load_val (MD_CNT_W'(MDU_CYCLES - 1)),
    .nonzero  (md_active)
  );

  always_comb begin
    stall_raw = load_hit | ld_active | (md_active & ifid_md_use);
    redirect  = branch_taken | ifid_jump | ifid_jr;
  end

  // Outputs are forced low for the whole reset cycle; a stalled branch must not flush.
  always_comb begin
    stall       = stall_raw & ~reset;
    pc_hold     = stall;
    ifid_hold   = stall;
    idex_bubble = stall;
    ifid_flush  = redirect & ~stall_raw & ~reset;
    md_busy     = md_active & ~reset;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall);
      flush_events <= flush_events + 32'(ifid_flush);
    end
  end
`endif

endmodule
